dac_iq_stream_sequencer: RTL and testbench



---
 rtl/dac_iq_stream_sequencer.sv | 149 ++++++++++++++
 tb/tb_dac_iq_stream_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_iq_stream_sequencer.sv
// rtl/dac_iq_stream_sequencer.sv - IQ-reset sequencer and dual valid/ready stream front-end for dac_dual_iq.
// Optional feature macro: DAC_SEQ_HOLD_LAST_EN (hold last accepted sample on underrun instead of midscale 0).
module dac_iq_stream_sequencer #(
  parameter int INT_DAC_DATA_WIDTH = 10,
  parameter int INT_RST_CYCLES     = 4,
  parameter int INT_CNT_WIDTH      = 16
) (
  input  logic                          in_clk_data,
  input  logic                          in_rst_n,
  input  logic                          in_enable,
  input  logic                          in_resync,
  input  logic [INT_DAC_DATA_WIDTH-1:0] in_data_ch1,
  input  logic [INT_DAC_DATA_WIDTH-1:0] in_data_ch2,
  input  logic                          in_valid_ch1,
  input  logic                          in_valid_ch2,
  output logic                          out_ready_ch1,
  output logic                          out_ready_ch2,
  input  logic                          in_dac_ready,
  output logic [INT_DAC_DATA_WIDTH-1:0] out_dac_data_ch1,
  output logic [INT_DAC_DATA_WIDTH-1:0] out_dac_data_ch2,
  output logic                          out_valid_ch1,
  output logic                          out_valid_ch2,
  output logic                          out_dac_rst,
  output logic                          out_running,
  output logic [1:0]                    out_state,
  output logic [INT_CNT_WIDTH-1:0]      out_underrun_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_ARM   = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [7:0]               RST_LAST = 8'(INT_RST_CYCLES - 1);
  localparam logic [INT_CNT_WIDTH-1:0] CNT_MAX  = {INT_CNT_WIDTH{1'b1}};
  localparam logic [INT_CNT_WIDTH-1:0] CNT_ONE  = INT_CNT_WIDTH'(1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] rst_cnt;
  logic [7:0] rst_cnt_nxt;
  logic       clr_cnt;
  logic       run_stay;
  logic       advance;
  logic       underrun;

  always_ff @(posedge in_clk_data or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= ST_IDLE;
      rst_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= rst_cnt_nxt;
    end
  end

  // in_enable low wins over everything; resync only matters in ARM and RUN.
  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    clr_cnt     = 1'b0;
    if (!in_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt   = ST_RESET;
          rst_cnt_nxt = 8'd0;
          clr_cnt     = 1'b1;
        end
        ST_RESET: begin
          if (rst_cnt == RST_LAST) state_nxt = ST_ARM;
          else rst_cnt_nxt = rst_cnt + 8'd1;
        end
        ST_ARM: begin
          if (in_resync) begin
            state_nxt   = ST_RESET;
            rst_cnt_nxt = 8'd0;
          end else if (in_valid_ch1 && in_valid_ch2 && in_dac_ready) begin
            state_nxt = ST_RUN;
          end
        end
        default: begin
          if (in_resync) begin
            state_nxt   = ST_RESET;
            rst_cnt_nxt = 8'd0;
          end
        end
      endcase
    end
  end

  // Ready drops in the same cycle as an exit so no sample is accepted and then dropped.
  assign run_stay      = (state == ST_RUN) && (state_nxt == ST_RUN);
  assign advance       = run_stay && in_dac_ready;
  assign underrun      = advance && !(in_valid_ch1 && in_valid_ch2);
  assign out_ready_ch1 = advance;
  assign out_ready_ch2 = advance;
  assign out_state     = state;

  always_ff @(posedge in_clk_data or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_dac_data_ch1 <= '0;
      out_dac_data_ch2 <= '0;
      out_valid_ch1    <= 1'b0;
      out_valid_ch2    <= 1'b0;
    end else if (!run_stay) begin
      out_dac_data_ch1 <= '0;
      out_dac_data_ch2 <= '0;
      out_valid_ch1    <= 1'b0;
      out_valid_ch2    <= 1'b0;
    end else if (in_dac_ready) begin
      out_valid_ch1 <= in_valid_ch1;
      out_valid_ch2 <= in_valid_ch2;
`ifdef DAC_SEQ_HOLD_LAST_EN
      // The data register already holds the last accepted sample; leave it on underrun.
      if (in_valid_ch1) out_dac_data_ch1 <= in_data_ch1;
      if (in_valid_ch2) out_dac_data_ch2 <= in_data_ch2;
`else
      out_dac_data_ch1 <= in_valid_ch1 ? in_data_ch1 : '0;
      out_dac_data_ch2 <= in_valid_ch2 ? in_data_ch2 : '0;
`endif
    end
  end

  always_ff @(posedge in_clk_data or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_underrun_cnt <= '0;
    end else if (clr_cnt) begin
      out_underrun_cnt <= '0;
    end else if (underrun && (out_underrun_cnt != CNT_MAX)) begin
      out_underrun_cnt <= out_underrun_cnt + CNT_ONE;
    end
  end

  // Status flags are driven from the next state so they change on the state edge.
  always_ff @(posedge in_clk_data or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_dac_rst <= 1'b1;
      out_running <= 1'b0;
    end else begin
      out_dac_rst <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
      out_running <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_dac_iq_stream_sequencer.sv
// tb/tb_dac_iq_stream_sequencer.sv - Self-checking bench for dac_iq_stream_sequencer with a cycle model.
module tb_dac_iq_stream_sequencer;
  localparam int W    = 10;
  localparam int RSTC = 4;
  localparam int CW   = 4;
`ifdef DAC_SEQ_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable = 0, resync = 0, v1 = 0, v2 = 0, dac_ready = 0;
  logic [W-1:0]  d1 = '0, d2 = '0;
  logic          ready1, ready2, ov1, ov2, dac_rst, running;
  logic [W-1:0]  od1, od2;
  logic [1:0]    st;
  logic [CW-1:0] cnt;

  dac_iq_stream_sequencer #(
    .INT_DAC_DATA_WIDTH(W), .INT_RST_CYCLES(RSTC), .INT_CNT_WIDTH(CW)
  ) u_dut (
    .in_clk_data(clk), .in_rst_n(rst_n), .in_enable(enable), .in_resync(resync),
    .in_data_ch1(d1), .in_data_ch2(d2), .in_valid_ch1(v1), .in_valid_ch2(v2),
    .out_ready_ch1(ready1), .out_ready_ch2(ready2), .in_dac_ready(dac_ready),
    .out_dac_data_ch1(od1), .out_dac_data_ch2(od2),
    .out_valid_ch1(ov1), .out_valid_ch2(ov2), .out_dac_rst(dac_rst),
    .out_running(running), .out_state(st), .out_underrun_cnt(cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 reset, 2 arm, 3 run; m_rleft counts reset cycles still owed.
  int       m_phase = 0, m_rleft = 0, m_cnt = 0, m_next = 0;
  bit       m_stay = 0;
  bit [W-1:0] m_d1 = 0, m_d2 = 0;
  bit       m_v1 = 0, m_v2 = 0, m_rst = 1, m_run = 0;

  task automatic model_reset();
    m_phase = 0; m_rleft = 0; m_cnt = 0;
    m_d1 = 0; m_d2 = 0; m_v1 = 0; m_v2 = 0; m_rst = 1; m_run = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      m_next = m_phase;
      if (!enable) m_next = 0;
      else if (m_phase == 0) begin m_next = 1; m_rleft = RSTC; m_cnt = 0; end
      else if (m_phase == 1) begin m_rleft--; if (m_rleft == 0) m_next = 2; end
      else if (resync) begin m_next = 1; m_rleft = RSTC; end
      else if (m_phase == 2 && v1 && v2 && dac_ready) m_next = 3;
      m_stay = (m_phase == 3) && (m_next == 3);
      if (!m_stay) begin
        m_d1 = 0; m_d2 = 0; m_v1 = 0; m_v2 = 0;
      end else if (dac_ready) begin
        m_d1 = v1 ? d1 : (HOLD ? m_d1 : '0);
        m_d2 = v2 ? d2 : (HOLD ? m_d2 : '0);
        m_v1 = v1; m_v2 = v2;
        if ((!v1 || !v2) && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      m_rst = (m_next <= 1); m_run = (m_next == 3); m_phase = m_next;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      check("ready_ch1", ready1, (m_phase == 3) && enable && !resync && dac_ready);
      check("ready_ch2", ready2, (m_phase == 3) && enable && !resync && dac_ready);
      check("data_ch1", od1, m_d1);
      check("data_ch2", od2, m_d2);
      check("valid_ch1", ov1, m_v1);
      check("valid_ch2", ov2, m_v2);
      check("dac_rst", dac_rst, m_rst);
      check("running", running, m_run);
      check("state", st, m_phase);
      check("underrun_cnt", cnt, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_reset(input string name);
    int n_rst;
    int cycles;
    n_rst = 0; cycles = 0;
    while (st == 2'd1 && cycles < 20) begin
      if (dac_rst) n_rst++;
      cycles++;
      tick();
    end
    check({name, "_len"}, n_rst, RSTC);
    check({name, "_to_arm"}, st, 2);
    check({name, "_rst_low"}, dac_rst, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("rst_state", st, 0);
    check("rst_dac_rst", dac_rst, 1);
    check("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    tick();

    enable = 1;
    tick();
    check("enter_reset", st, 1);
    count_reset("startup");

    d1 = 10'h123; v1 = 1; dac_ready = 1;
    repeat (5) begin
      tick();
      check("arm_hold", st, 2);
      check("arm_ready", ready1, 0);
    end
    d2 = 10'h3FE; v2 = 1;
    tick();
    check("run_entry", st, 3);
    check("run_entry_data", od1, 0);
    tick();
    check("first_ch1", od1, 10'h123);
    check("first_ch2", od2, 10'h3FE);
    check("first_valid", {ov1, ov2}, 2'b11);

    for (int i = 1; i <= 4; i++) begin
      d1 = W'(i); d2 = 10'h055;
      tick();
    end
    v2 = 0; d2 = 10'h2AA;
    repeat (3) begin
      tick();
      check("gap_valid2", ov2, 0);
      check("gap_data2", od2, HOLD ? 10'h055 : 10'h000);
    end
    check("gap_cnt", cnt, 3);

    v2 = 1; d2 = 10'h0AA; v1 = 0; dac_ready = 0;
    #1 check("stall_ready", ready1, 0);
    repeat (2) tick();
    check("stall_d1", od1, 10'h004);
    check("stall_d2", od2, HOLD ? 10'h055 : 10'h000);
    check("stall_cnt", cnt, 3);

    dac_ready = 1; v1 = 1; d1 = 10'h111; d2 = 10'h222; resync = 1;
    #1 check("resync_ready", ready1, 0);
    tick();
    resync = 0;
    check("resync_state", st, 1);
    count_reset("resync");
    tick();
    check("rearm_run", st, 3);
    tick();
    resync = 1; enable = 0;
    tick();
    check("prio_idle", st, 0);
    check("prio_rst", dac_rst, 1);
    check("prio_data", od1, 0);
    resync = 0; enable = 1; v1 = 0; v2 = 0;
    tick();
    count_reset("restart");
    v1 = 1; v2 = 1;
    tick();
    check("sat_run", st, 3);
    v1 = 0; v2 = 0;
    repeat (20) tick();
    check("sat_cnt", cnt, 15);

    #1 rst_n = 1'b0;
    #1;
    check("async_state", st, 0);
    check("async_dac_rst", dac_rst, 1);
    check("async_running", running, 0);
    check("async_cnt", cnt, 0);
    check("async_data", {ov1, od1}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
